// File: rtl/branch_resolver.sv
// Branch resolver: resolves short conditional jumps (Jcc rel8) and INTO
// using the prefetch-queue displacement byte and the jump-test result.
module branch_resolver (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [7:0]  opcode_i,
   input  logic [15:0] ip_i,
   input  logic        taken_i,
   input  logic [7:0]  q_byte_i,
   input  logic        q_valid_i,
   output logic        q_rd_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        load_ip_o,
   output logic        flush_o,
   output logic [15:0] new_ip_o,
   output logic        int_req_o,
   output logic [7:0]  int_vector_o
);

   // state   | meaning
   // IDLE    | waiting for start; unsupported opcodes complete from here
   // FETCH   | popping the rel8 displacement from the prefetch queue
   // RESOLVE | sampling taken, computing the Jcc target
   // TRAP    | sampling taken (overflow) for INTO
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      RESOLVE = 2'd2,
      TRAP    = 2'd3
   } state_t;

   localparam logic [7:0] OP_INTO  = 8'hCE;
   localparam logic [7:0] VEC_INTO = 8'h04;

   state_t      state_q, state_d;
   logic [15:0] ip_q, ip_d;
   logic [7:0]  disp_q, disp_d;
   logic        done_q, done_d;
   logic        load_q, load_d;
   logic        int_req_q, int_req_d;
   logic [15:0] new_ip_q, new_ip_d;
   logic [7:0]  int_vec_q, int_vec_d;
   logic [15:0] target;

   // ip already points past the opcode; +1 skips the displacement byte
   assign target = ip_q + 16'd1 + {{8{disp_q[7]}}, disp_q};

   always_comb begin
      state_d   = state_q;
      ip_d      = ip_q;
      disp_d    = disp_q;
      done_d    = 1'b0;
      load_d    = 1'b0;
      int_req_d = 1'b0;
      new_ip_d  = new_ip_q;
      int_vec_d = int_vec_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               ip_d = ip_i;
               if (opcode_i[7:4] == 4'h7) begin
                  state_d = FETCH;
               end else if (opcode_i == OP_INTO) begin
                  state_d = TRAP;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (q_valid_i) begin
               disp_d  = q_byte_i;
               state_d = RESOLVE;
            end
         end
         RESOLVE: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (taken_i) begin
               load_d   = 1'b1;
               new_ip_d = target;
            end
         end
         TRAP: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (taken_i) begin
               int_req_d = 1'b1;
               int_vec_d = VEC_INTO;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         ip_q      <= 16'h0000;
         disp_q    <= 8'h00;
         done_q    <= 1'b0;
         load_q    <= 1'b0;
         int_req_q <= 1'b0;
         new_ip_q  <= 16'h0000;
         int_vec_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         ip_q      <= ip_d;
         disp_q    <= disp_d;
         done_q    <= done_d;
         load_q    <= load_d;
         int_req_q <= int_req_d;
         new_ip_q  <= new_ip_d;
         int_vec_q <= int_vec_d;
      end
   end

   assign q_rd_o       = (state_q == FETCH);
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign load_ip_o    = load_q;
   assign flush_o      = load_q;
   assign int_req_o    = int_req_q;
   assign new_ip_o     = new_ip_q;
   assign int_vector_o = int_vec_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed scenarios plus randomized requests
// checked against a transaction-level timeline model.
module tb_branch_resolver;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  opcode;
   logic [15:0] ip;
   logic        taken;
   logic [7:0]  q_byte;
   logic        q_valid;
   logic        q_rd;
   logic        busy;
   logic        done;
   logic        load_ip;
   logic        flush;
   logic [15:0] new_ip;
   logic        int_req;
   logic [7:0]  int_vector;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_new_ip = 16'h0000;
   logic [7:0]  exp_vec = 8'h00;

   branch_resolver dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (start),
      .opcode_i     (opcode),
      .ip_i         (ip),
      .taken_i      (taken),
      .q_byte_i     (q_byte),
      .q_valid_i    (q_valid),
      .q_rd_o       (q_rd),
      .busy_o       (busy),
      .done_o       (done),
      .load_ip_o    (load_ip),
      .flush_o      (flush),
      .new_ip_o     (new_ip),
      .int_req_o    (int_req),
      .int_vector_o (int_vector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: target = (ip + 1 + signed disp) mod 65536
   function automatic logic [15:0] branch_target(input logic [15:0] ipv, input logic [7:0] disp);
      int t;
      t = int'(ipv) + 1 + ((disp > 8'd127) ? int'(disp) - 256 : int'(disp));
      if (t < 0) t = t + 65536;
      if (t >= 65536) t = t - 65536;
      return t[15:0];
   endfunction

   // Drives one request starting now (caller sits just after a falling edge)
   // and compares every following cycle against the expected request timeline.
   task automatic run_req(input string name, input logic [7:0] op, input logic [15:0] ipv,
                          input logic [7:0] disp, input logic tk, input int stall, input bit noise);
      bit jcc;
      bit into;
      int lat;
      int pops;
      logic e_busy, e_done, e_load, e_int, e_qrd;
      jcc  = (op >= 8'h70) && (op <= 8'h7F);
      into = (op == 8'hCE);
      lat  = jcc ? 3 + stall : (into ? 2 : 1);
      pops = 0;
      start   = 1'b1;
      opcode  = op;
      ip      = ipv;
      taken   = tk;
      q_valid = jcc ? (stall == 0) : 1'($urandom_range(0, 1));
      q_byte  = (jcc && stall == 0) ? disp : 8'($urandom);
      if (q_rd && q_valid) pops++;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         e_busy = (c < lat);
         e_done = (c == lat);
         e_load = jcc && tk && (c == lat);
         e_int  = into && tk && (c == lat);
         e_qrd  = jcc && (c <= stall + 1);
         if (e_load) exp_new_ip = branch_target(ipv, disp);
         if (e_int) exp_vec = 8'h04;
         checks++;
         if (busy !== e_busy) begin failures++; $display("FAIL %s busy c%0d: got %b want %b", name, c, busy, e_busy); end
         checks++;
         if (done !== e_done) begin failures++; $display("FAIL %s done c%0d: got %b want %b", name, c, done, e_done); end
         checks++;
         if (load_ip !== e_load) begin failures++; $display("FAIL %s load_ip c%0d: got %b want %b", name, c, load_ip, e_load); end
         checks++;
         if (flush !== e_load) begin failures++; $display("FAIL %s flush c%0d: got %b want %b", name, c, flush, e_load); end
         checks++;
         if (int_req !== e_int) begin failures++; $display("FAIL %s int_req c%0d: got %b want %b", name, c, int_req, e_int); end
         checks++;
         if (q_rd !== e_qrd) begin failures++; $display("FAIL %s q_rd c%0d: got %b want %b", name, c, q_rd, e_qrd); end
         checks++;
         if (new_ip !== exp_new_ip) begin failures++; $display("FAIL %s new_ip c%0d: got %h want %h", name, c, new_ip, exp_new_ip); end
         checks++;
         if (int_vector !== exp_vec) begin failures++; $display("FAIL %s int_vector c%0d: got %h want %h", name, c, int_vector, exp_vec); end
         if (noise && c < lat) begin
            start  = 1'($urandom_range(0, 1));
            opcode = 8'($urandom);
            ip     = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         if (jcc) begin
            q_valid = (c > stall);
            q_byte  = q_valid ? disp : 8'($urandom);
         end else begin
            q_valid = 1'($urandom_range(0, 1));
            q_byte  = 8'($urandom);
         end
         if (q_rd && q_valid) pops++;
      end
      checks++;
      if (pops !== (jcc ? 1 : 0)) begin
         failures++;
         $display("FAIL %s pops: got %0d want %0d", name, pops, jcc ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; opcode = 8'h00; ip = 16'h0000;
      taken = 1'b0; q_byte = 8'h00; q_valid = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, load_ip, flush, int_req, q_rd} !== 6'b0) begin
         failures++;
         $display("FAIL reset_strobes: got %b want 000000", {busy, done, load_ip, flush, int_req, q_rd});
      end
      checks++;
      if (new_ip !== 16'h0000 || int_vector !== 8'h00) begin
         failures++;
         $display("FAIL reset_values: got %h/%h want 0000/00", new_ip, int_vector);
      end
      reset = 1'b0;
      run_req("first_after_reset", 8'h7A, 16'h0100, 8'h05, 1'b1, 0, 1'b0);
   endtask

   task automatic test_je_taken();
      run_req("je_taken", 8'h74, 16'h1000, 8'h10, 1'b1, 0, 1'b0);
      checks++;
      if (new_ip !== 16'h1011 || load_ip !== 1'b1 || flush !== 1'b1 || done !== 1'b1) begin
         failures++;
         $display("FAIL je_taken_final: got ip=%h ld=%b fl=%b dn=%b want 1011 1 1 1", new_ip, load_ip, flush, done);
      end
   endtask

   task automatic test_jne_not_taken();
      run_req("jne_not_taken", 8'h75, 16'h2345, 8'hF0, 1'b0, 0, 1'b0);
      checks++;
      if (done !== 1'b1 || load_ip !== 1'b0 || new_ip !== 16'h1011) begin
         failures++;
         $display("FAIL jne_final: got dn=%b ld=%b ip=%h want 1 0 1011", done, load_ip, new_ip);
      end
   endtask

   task automatic test_wrap();
      run_req("backward_wrap", 8'h7C, 16'h0002, 8'hF0, 1'b1, 0, 1'b0);
      checks++;
      if (new_ip !== 16'hFFF3) begin failures++; $display("FAIL backward_wrap: got %h want FFF3", new_ip); end
      run_req("forward_wrap", 8'h70, 16'hFFFF, 8'h00, 1'b1, 1, 1'b0);
      checks++;
      if (new_ip !== 16'h0000) begin failures++; $display("FAIL forward_wrap: got %h want 0000", new_ip); end
      run_req("max_fwd", 8'h7F, 16'hFF80, 8'h7F, 1'b1, 0, 1'b0);
      checks++;
      if (new_ip !== 16'h0000) begin failures++; $display("FAIL max_fwd: got %h want 0000", new_ip); end
   endtask

   task automatic test_into();
      run_req("into_no_ovf", 8'hCE, 16'h4000, 8'h00, 1'b0, 0, 1'b0);
      checks++;
      if (int_req !== 1'b0 || int_vector !== 8'h00) begin
         failures++;
         $display("FAIL into_no_ovf: got req=%b vec=%h want 0 00", int_req, int_vector);
      end
      run_req("into_ovf", 8'hCE, 16'h4001, 8'h00, 1'b1, 0, 1'b0);
      checks++;
      if (int_req !== 1'b1 || int_vector !== 8'h04 || done !== 1'b1) begin
         failures++;
         $display("FAIL into_ovf: got req=%b vec=%h dn=%b want 1 04 1", int_req, int_vector, done);
      end
   endtask

   task automatic test_unsupported();
      run_req("unsup_6F", 8'h6F, 16'h1234, 8'h00, 1'b1, 0, 1'b0);
      run_req("unsup_80", 8'h80, 16'h1234, 8'h00, 1'b1, 0, 1'b0);
      run_req("unsup_CD", 8'hCD, 16'h1234, 8'h00, 1'b1, 0, 1'b0);
      run_req("unsup_CF", 8'hCF, 16'h1234, 8'h00, 1'b1, 0, 1'b0);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL unsup_quiet: got dn=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_stall_abort();
      start = 1'b1; opcode = 8'h72; ip = 16'h5555; taken = 1'b1;
      q_valid = 1'b0; q_byte = 8'h33;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (busy !== 1'b1 || q_rd !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL stall c%0d: got busy=%b q_rd=%b dn=%b want 1 1 0", c, busy, q_rd, done);
         end
      end
      reset = 1'b1;
      q_valid = 1'b1;
      #1;
      exp_new_ip = 16'h0000;
      exp_vec = 8'h00;
      checks++;
      if ({busy, done, load_ip, flush, int_req, q_rd} !== 6'b0 || new_ip !== 16'h0000 || int_vector !== 8'h00) begin
         failures++;
         $display("FAIL abort_reset: got %b ip=%h vec=%h want 000000 0000 00",
                  {busy, done, load_ip, flush, int_req, q_rd}, new_ip, int_vector);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, done, load_ip, int_req, q_rd} !== 5'b0) begin
            failures++;
            $display("FAIL post_abort c%0d: got %b want 00000", c, {busy, done, load_ip, int_req, q_rd});
         end
      end
      run_req("after_abort", 8'h74, 16'h1000, 8'h10, 1'b1, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_req("b2b_into_a", 8'hCE, 16'h0010, 8'h00, 1'b1, 0, 1'b1);
      run_req("b2b_into_b", 8'hCE, 16'h0020, 8'h00, 1'b0, 0, 1'b1);
      run_req("b2b_jcc", 8'h7E, 16'h3000, 8'h81, 1'b1, 2, 1'b1);
      run_req("b2b_unsup", 8'h90, 16'h3000, 8'h00, 1'b1, 0, 1'b1);
      run_req("b2b_jcc2", 8'h71, 16'h8000, 8'h7F, 1'b1, 0, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] op;
      int kind;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         if (kind <= 1) op = 8'h70 | 8'($urandom_range(0, 15));
         else if (kind == 2) op = 8'hCE;
         else begin
            op = 8'($urandom);
            if (op[7:4] == 4'h7 || op == 8'hCE) op = 8'h90;
         end
         run_req("random", op, 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            start = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, done, load_ip, int_req} !== 4'b0 || new_ip !== exp_new_ip) begin
               failures++;
               $display("FAIL random_idle: got %b ip=%h want 0000 ip=%h",
                        {busy, done, load_ip, int_req}, new_ip, exp_new_ip);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_je_taken();
      test_jne_not_taken();
      test_wrap();
      test_into();
      test_unsupported();
      test_stall_abort();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle request; opcode and ip are valid in this cycle.
REQ-004 opcode  input  8  instruction opcode byte of the request.
REQ-005 ip  input  16  address of the byte following the opcode.
REQ-006 taken  input  1  condition result from the jump-test stage; combinational on the current opcode and flags.
REQ-007 q_byte  input  8  head byte of the prefetch queue.
REQ-008 q_valid  input  1  q_byte is valid.
REQ-009 q_rd  output  1  pop request; a byte is consumed only in a cycle with q_valid & q_rd.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 load_ip  output  1  one-cycle pulse; the IP register loads new_ip.
REQ-013 flush  output  1  one-cycle pulse; the prefetch queue is discarded. Always coincides with load_ip.
REQ-014 new_ip  output  16  branch target; valid while load_ip is high.
REQ-015 int_req  output  1  one-cycle software-interrupt request.
REQ-016 int_vector  output  8  interrupt vector; valid while int_req is high.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, RESOLVE and TRAP.
REQ-018 In IDLE with start=1, the block SHALL capture opcode and ip. Next state by opcode:
- 0x70-0x7F (Jcc): FETCH.
- 0xCE (INTO): TRAP.
- Any other opcode: stay in IDLE and pulse done in the following cycle, with no other output asserted.
REQ-019 In FETCH, q_rd SHALL be 1 and is combinational on state. On q_valid=1 the block SHALL capture q_byte as disp and go to RESOLVE. While q_valid=0 it SHALL stay in FETCH indefinitely.
REQ-020 In RESOLVE, the block SHALL sample taken for exactly one cycle. Registered outputs, visible in the next cycle:
- done=1.
- If taken=1: load_ip=1, flush=1, new_ip = (ip_captured + 1 + sign_extend(disp)) mod 2^16.
- If taken=0: load_ip=0, flush=0.
The FSM then returns to IDLE.
REQ-021 In TRAP, the block SHALL sample taken for one cycle. Registered outputs, visible in the next cycle:
- done=1.
- If taken=1: int_req=1, int_vector=8'h04.
- If taken=0: int_req=0.
The FSM then returns to IDLE.
REQ-022 Address arithmetic SHALL be 16-bit and wrap silently. Example: ip=16'hFFFF, disp=8'h00 gives new_ip=16'h0000.
REQ-023 start asserted while busy=1 SHALL be ignored. The captured opcode, ip and disp SHALL NOT change.
REQ-024 Latency, measured from the start cycle (cycle 0) to done:
- INTO: done in cycle 2.
- Unsupported opcode: done in cycle 1.
- Jcc with q_valid already high: done in cycle 3. Each cycle q_valid stays low adds one cycle.
REQ-025 done, load_ip, flush and int_req SHALL each be high for exactly one cycle per request and SHALL be 0 in all other cycles.
REQ-026 new_ip and int_vector SHALL hold their last values when not strobed.
REQ-027 start may be accepted in the same cycle that done is high, because the FSM is already in IDLE.
REQ-028 At most one byte SHALL be popped per Jcc request. INTO and unsupported opcodes SHALL never assert q_rd.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE and these outputs SHALL be 0: busy, done, load_ip, flush, int_req, q_rd.
REQ-030 While reset=1, new_ip SHALL be 16'h0000 and int_vector SHALL be 8'h00.
REQ-031 Reset asserted mid-operation (FETCH, RESOLVE or TRAP) SHALL abort the request and discard the captured values. No done, load_ip or int_req pulse SHALL follow the release of reset.
REQ-032 After reset is released, the first start SHALL be accepted in the first clock edge.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- JE taken: start, opcode=8'h74, ip=16'h1000, taken=1, q_byte=8'h10 with q_valid=1 -> in cycle 3, done=1, load_ip=1, flush=1, new_ip=16'h1011.
- JNE not taken: opcode=8'h75, taken=0, q_byte=8'hF0 -> in cycle 3, done=1, load_ip=0; exactly one q_rd handshake occurs.
- Backward wrap: ip=16'h0002, disp=8'hF0 -> new_ip=16'hFFF3.
- INTO with overflow: opcode=8'hCE, taken=1 -> in cycle 2, int_req=1, int_vector=8'h04; q_rd=0 throughout.
- Queue stall plus abort: Jcc with q_valid=0 for 5 cycles -> busy=1 and q_rd=1 throughout. Then assert reset -> all outputs 0; a new start after reset completes normally.
- Back-to-back requests: start during busy is ignored. start in the done cycle is accepted, with its done 2 cycles later for INTO.
